// File: rtl/fft_ctrl_axil.sv
// fft_ctrl_axil
//   AXI4-Lite slave register block and run sequencer for the FFT core.
//   Software programs CONFIG and issues COMMANDs (start/stop/abort). The
//   block hands the configuration to the core with a valid/ready handshake,
//   gates the core run, counts completed frames and reports status.
//
//   Optional feature: define FFT_CTRL_IRQ_EN to add IRQ_STATUS (word 4,
//   RW1C) and IRQ_ENABLE (word 5) plus a registered irq output. Without it
//   words 4/5 are unmapped and irq is tied low.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*     write channels (full-word writes, no WSTRB)
//   S_AXI_AR*/R*        read channels
//   fft_ifft/point/final_shift/scaling   configuration to the core
//   fft_cfg_valid/ready configuration handshake
//   fft_run             core enabled to process frames
//   fft_abort           one-cycle flush pulse
//   fft_frame_done      one-cycle pulse per completed frame
//   irq                 interrupt (0 unless FFT_CTRL_IRQ_EN)
//
// Register map (word index = ADDR[ADDR_W-1:2])
//   0 CONFIG      RW  [31] ifft [30:27] point [26:22] final_shift [21:4] scaling
//   1 COMMAND     WO  [1:0] 0=nop 1=start 2=stop 3=abort
//   2 STATUS      RO  [1:0] state [2] cfg_err [3] fft_run
//   3 FRAME_COUNT RO  zero-extended
module fft_ctrl_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int FRAME_CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          fft_ifft,
    output logic [3:0]                    fft_point,
    output logic [4:0]                    fft_final_shift,
    output logic [17:0]                   fft_scaling,
    output logic                          fft_cfg_valid,
    input  logic                          fft_cfg_ready,
    output logic                          fft_run,
    output logic                          fft_abort,
    input  logic                          fft_frame_done,
    output logic                          irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } run_state_t;

    wr_state_t               wst;
    run_state_t              st, st_nxt;
    logic [IDX_W-1:0]        aw_idx;
    logic [IDX_W-1:0]        ar_idx;
    logic [27:0]             cfg_reg;   // CONFIG[31:4]; [3:0] always read as 0
    logic [27:0]             cfg_act;   // snapshot driven to the core
    logic                    cfg_err;
    logic [FRAME_CNT_W-1:0]  frame_cnt;
    logic                    wr_commit, cmd_wr;
    logic                    cmd_start, cmd_stop, cmd_abort;
    logic                    point_ok, start_go, start_bad;
    logic                    wr_mapped;
    logic [31:0]             rd_data;
    logic                    rd_err;
    logic                    unused_ok;

    assign unused_ok = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[3:2]};

    // ---------------- write path ----------------
    assign S_AXI_AWREADY = (wst == W_ADDR);
    assign S_AXI_WREADY  = (wst == W_DATA);
    assign S_AXI_BVALID  = (wst == W_RESP);
    assign wr_commit     = (wst == W_DATA) && S_AXI_WVALID;

`ifdef FFT_CTRL_IRQ_EN
    assign wr_mapped = (aw_idx <= IDX_W'(5));
`else
    assign wr_mapped = (aw_idx <= IDX_W'(3));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst         <= W_ADDR;
            aw_idx      <= '0;
            S_AXI_BRESP <= '0;
        end else begin
            case (wst)
                W_ADDR: if (S_AXI_AWVALID) begin
                    aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    wst    <= W_DATA;
                end
                W_DATA: if (S_AXI_WVALID) begin
                    S_AXI_BRESP <= wr_mapped ? 2'b00 : 2'b10;
                    wst         <= W_RESP;
                end
                W_RESP: if (S_AXI_BREADY) wst <= W_ADDR;
                default: wst <= W_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_reg <= '0;
        else if (wr_commit && aw_idx == IDX_W'(0))
            cfg_reg <= S_AXI_WDATA[31:4];
    end

    // ---------------- command decode ----------------
    assign cmd_wr    = wr_commit && (aw_idx == IDX_W'(1));
    assign cmd_start = cmd_wr && (S_AXI_WDATA[1:0] == 2'd1);
    assign cmd_stop  = cmd_wr && (S_AXI_WDATA[1:0] == 2'd2);
    assign cmd_abort = cmd_wr && (S_AXI_WDATA[1:0] == 2'd3);
    assign point_ok  = (cfg_reg[26:23] >= 4'd3) && (cfg_reg[26:23] <= 4'd12);
    assign start_go  = cmd_start && (st == S_IDLE) && point_ok;
    assign start_bad = cmd_start && (st == S_IDLE) && !point_ok;

    // ---------------- run sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= S_IDLE;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (cmd_abort) begin
            st_nxt = S_IDLE;
        end else begin
            case (st)
                S_IDLE:  if (start_go)       st_nxt = S_LOAD;
                S_LOAD:  if (fft_cfg_ready)  st_nxt = S_RUN;
                S_RUN:   if (cmd_stop)       st_nxt = S_DRAIN;
                S_DRAIN: if (fft_frame_done) st_nxt = S_IDLE;
                default: st_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fft_cfg_valid = (st == S_LOAD);
        fft_run       = (st == S_RUN);
    end

    assign fft_ifft        = cfg_act[27];
    assign fft_point       = cfg_act[26:23];
    assign fft_final_shift = cfg_act[22:18];
    assign fft_scaling     = cfg_act[17:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_act   <= '0;
            cfg_err   <= 1'b0;
            frame_cnt <= '0;
            fft_abort <= 1'b0;
        end else begin
            fft_abort <= cmd_abort;
            if (start_go) begin
                cfg_act   <= cfg_reg;
                cfg_err   <= 1'b0;
                frame_cnt <= '0;
            end else begin
                if (start_bad) cfg_err <= 1'b1;
                // Counting stays on in DRAIN; a done coinciding with stop is still in RUN.
                if (fft_frame_done && (st == S_RUN || st == S_DRAIN) && frame_cnt != '1)
                    frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // ---------------- interrupt ----------------
`ifdef FFT_CTRL_IRQ_EN
    logic [1:0] irq_status, irq_enable, irq_set, irq_clr;
    logic       irq_q;

    assign irq_set = {start_bad, (st == S_DRAIN) && fft_frame_done && !cmd_abort};
    assign irq_clr = (wr_commit && aw_idx == IDX_W'(4)) ? S_AXI_WDATA[1:0] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
            irq_enable <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            if (wr_commit && aw_idx == IDX_W'(5)) irq_enable <= S_AXI_WDATA[1:0];
            irq_q <= |(irq_status & irq_enable);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- read path ----------------
    assign ar_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign S_AXI_ARREADY = !S_AXI_RVALID;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (ar_idx)
            IDX_W'(0): rd_data = {cfg_reg, 4'b0000};
            IDX_W'(1): rd_data = '0;
            IDX_W'(2): rd_data = {28'd0, fft_run, cfg_err, 2'(st)};
            IDX_W'(3): rd_data = 32'(frame_cnt);
`ifdef FFT_CTRL_IRQ_EN
            IDX_W'(4): rd_data = {30'd0, irq_status};
            IDX_W'(5): rd_data = {30'd0, irq_enable};
`endif
            default:   rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= '0;
        end else if (!S_AXI_RVALID) begin
            if (S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_err ? 2'b10 : 2'b00;
            end
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: doc/fft_ctrl_axil.md
Name: fft_ctrl_axil

Overview:
- AXI4-Lite slave register block plus run sequencer for the FFT core.
- Software writes CONFIG (ifft, point, final_shift, scaling) and COMMAND (start/stop/abort).
- The block pushes the configuration to the core with a valid/ready handshake, gates the core run, counts completed frames and reports status.
- Sits between the PS AXI-Lite interconnect and the FFT datapath.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 9, AXI-Lite byte address width; word index = ADDR[ADDR_W-1:2].
- FRAME_CNT_W, 16, width of the frame counter; must be 31 or less.

Ports:
- clk  in  1  single clock for everything.
- rst_n  in  1  asynchronous active-low reset (one clock; reset asynchronous, active-low).
- S_AXI_AWADDR / S_AXI_AWVALID / S_AXI_AWREADY  in/in/out  ADDR_W/1/1  write address channel.
- S_AXI_WDATA / S_AXI_WVALID / S_AXI_WREADY  in/in/out  32/1/1  write data channel (WSTRB not used; full-word writes).
- S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / S_AXI_ARVALID / S_AXI_ARREADY  in/in/out  ADDR_W/1/1  read address channel.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  32/2/1/1  read data channel.
- fft_ifft  out  1  configuration: inverse transform.
- fft_point  out  4  configuration: log2 of the FFT size.
- fft_final_shift  out  5  configuration: final shift.
- fft_scaling  out  18  configuration: per-stage scaling schedule.
- fft_cfg_valid  out  1  configuration valid.
- fft_cfg_ready  in  1  core accepts the configuration.
- fft_run  out  1  core enabled to process frames.
- fft_abort  out  1  one-cycle pulse: flush the core.
- fft_frame_done  in  1  one-cycle pulse per completed frame.
- irq  out  1  interrupt (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs are 0; the shadow CONFIG register is 0.
  - FSM is IDLE; frame counter is 0; cfg_err is 0.
- Write path: one write in flight at a time.
  - W_ADDR: AWREADY=1. When AWVALID is high at a clock edge, latch the word index and go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. When WVALID is high, latch WDATA and commit the register write on that same edge; go to W_RESP.
  - W_RESP: BVALID=1 until BREADY is high; then return to W_ADDR.
  - AW and W are never accepted in the same cycle.
  - BRESP is 2'b00 for mapped addresses and 2'b10 (SLVERR) for unmapped ones; unmapped writes have no effect.
- Read path:
  - ARREADY=1 when RVALID=0.
  - RDATA is registered and RVALID=1 the cycle after AR acceptance; hold until RREADY.
  - Unmapped reads return 0 with RRESP=2'b10.
  - Reads and writes operate independently.
- Register map (word index):
  - 0 CONFIG, RW: [31] ifft, [30:27] point, [26:22] final_shift, [21:4] scaling, [3:0] reserved (reads 0).
  - 1 COMMAND, WO, reads 0: [1:0] 0=nop, 1=start, 2=stop, 3=abort.
  - 2 STATUS, RO: [1:0] FSM state, [2] cfg_err, [3] fft_run.
  - 3 FRAME_COUNT, RO, zero-extended.
- FSM states: IDLE=0, LOAD=1, RUN=2, DRAIN=3.
  - IDLE + start: if point is in 3..12, clear cfg_err and the frame counter and go to LOAD. Otherwise set cfg_err and stay in IDLE.
  - LOAD: fft_cfg_valid=1 with fft_* driven from the shadow register captured at the start command. On fft_cfg_ready, go to RUN.
  - RUN: fft_run=1. Each fft_frame_done increments the frame counter, saturating at all-ones. On stop, go to DRAIN.
  - DRAIN: fft_run=0. The next fft_frame_done is still counted, then go to IDLE.
  - Abort from any state: one-cycle fft_abort pulse, go to IDLE, fft_cfg_valid and fft_run low next cycle. The frame counter is kept.
  - Start outside IDLE, stop in IDLE/LOAD, and nop are all ignored.
- CONFIG writes outside IDLE update the register only; the core sees the new value at the next start.
- fft_* configuration outputs are held stable from LOAD until IDLE.
- fft_frame_done in the same cycle as a stop command in RUN is counted, and the FSM still enters DRAIN.

Optional Feature:
- Macro: FFT_CTRL_IRQ_EN.
- With the macro defined:
  - Word index 4 is IRQ_STATUS, RW1C: [0] done (set on DRAIN→IDLE), [1] cfg_err event.
  - Word index 5 is IRQ_ENABLE, RW, [1:0].
  - irq = |(status & enable), registered.
- Without the macro: indices 4 and 5 are unmapped (SLVERR) and irq is tied to 0.

Test Plan:
- Write CONFIG=0x48155550 using AW and W accepted on consecutive cycles -> BRESP=0; CONFIG reads back 0x48155550.
- Write COMMAND=1 -> fft_cfg_valid=1 with point=9, scaling=18'h15555. Hold fft_cfg_ready high 3 cycles later -> STATUS=2 and fft_run=1.
- In RUN, issue 5 fft_frame_done pulses, then write COMMAND=2, then 1 more pulse -> STATUS=0, FRAME_COUNT=6.
- Write CONFIG with point=2, then start -> STATUS=0x4 (cfg_err=1, IDLE), fft_cfg_valid stays 0.
- In RUN, write COMMAND=3 -> fft_abort high for exactly 1 cycle, STATUS=0; assert rst_n=0 mid-write -> all outputs 0, BVALID=0.
- Read index 7 -> RRESP=2'b10, RDATA=0. With FFT_CTRL_IRQ_EN, set IRQ_ENABLE=1 and complete a run -> irq=1; write 1 to IRQ_STATUS -> irq=0.
